// File: rtl/axil_regbank_param.sv
// axil_regbank_param
// ------------------
// AXI4-Lite slave register bank with NUM_REGS registers of DATA_WIDTH bits.
// The lowest NUM_REGS-NUM_RO registers are writable and honour WSTRB byte
// strobes. The top NUM_RO registers are read-only status words taken from
// status_in. Bad accesses are answered with SLVERR: out-of-range reads and
// writes, and writes to read-only slots.
//
// Ports
//   ACLK, ARESET       clock (rising edge) and synchronous active-high reset
//   S_AXI_AW*/W*/B*    AXI4-Lite write address, write data and write response
//   S_AXI_AR*/R*       AXI4-Lite read address and read data
//   reg_out            flattened register contents; read-only slots drive 0
//   reg_wr_pulse       one-cycle strobe per successful write, one bit per register
//   status_in          flattened status words returned for the read-only slots
module axil_regbank_param #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter int          NUM_REGS   = 16,
    parameter int          NUM_RO     = 4,
    parameter int unsigned RESET_VAL  = 0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse,
    // Kept at least one word wide so a bank without status words still elaborates.
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_in
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam int NUM_WR = NUM_REGS - NUM_RO;

    // One extra bit so that NUM_REGS == 2**IDX_W still compares correctly.
    localparam logic [IDX_W:0]      NREG_X   = (IDX_W + 1)'(NUM_REGS);
    localparam logic [IDX_W:0]      NWR_X    = (IDX_W + 1)'(NUM_WR);
    localparam logic [DATA_WIDTH-1:0] RST_WORD = DATA_WIDTH'(RESET_VAL);
    localparam logic [1:0]          RESP_OKAY   = 2'b00;
    localparam logic [1:0]          RESP_SLVERR = 2'b10;

    // Write-side state
    logic                  aw_full_q, aw_full_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   pulse_q, pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_WR];
    logic [DATA_WIDTH-1:0] regs_d [NUM_WR];

    // Read-side state
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  awready, wready, arready;
    logic                  aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] rd_word [NUM_REGS];
    logic                  unused_bits;

    assign awready = !ARESET && !aw_full_q && !bvalid_q;
    assign wready  = !ARESET && !w_full_q && !bvalid_q;
    assign arready = !ARESET && !rvalid_q;
    assign aw_hs   = S_AXI_AWVALID && awready;
    assign w_hs    = S_AXI_WVALID && wready;
    assign ar_hs   = S_AXI_ARVALID && arready;
    assign commit  = aw_full_q && w_full_q;
    assign wr_ok   = {1'b0, aw_idx_q} < NWR_X;
    assign ar_idx  = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0],
                           S_AXI_ARADDR[LSB-1:0], status_in};

    // Per-slot read source and flattened register view.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slot
        if (gi < NUM_WR) begin : g_rw
            assign rd_word[gi] = regs_q[gi];
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
        end else begin : g_ro
            assign rd_word[gi] = status_in[(gi-NUM_WR)*DATA_WIDTH +: DATA_WIDTH];
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
    end

    // Write path: independent AW/W capture, commit once both are held.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        pulse_d   = '0;
        regs_d    = regs_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        // Flags only fill while BVALID is low, so commit never overlaps a
        // pending response.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_ok && ({1'b0, aw_idx_q} == (IDX_W + 1)'(i))) begin
                    pulse_d[i] = 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) begin
                            regs_d[i][b*8 +: 8] = w_data_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read path: registers are sampled before any same-edge write lands.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            if ({1'b0, ar_idx} < NREG_X) begin
                rresp_d = RESP_OKAY;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if ({1'b0, ar_idx} == (IDX_W + 1)'(i)) begin
                        rdata_d = rd_word[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            pulse_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int i = 0; i < NUM_WR; i++) begin
                regs_q[i] <= RST_WORD;
            end
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            pulse_q   <= pulse_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_wr_pulse  = pulse_q;

endmodule
